nibble_logic_unit: RTL and testbench



---
 rtl/nibble_logic_unit_pkg.sv | 25 ++
 rtl/nibble_logic_unit_logic_chunk.sv | 31 +++
 rtl/nibble_logic_unit.sv | 106 ++++++++++
 tb/tb_nibble_logic_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_logic_unit_pkg.sv
// ============================================================================
// nibble_logic_unit_pkg : shared op encodings, FSM states and default sizes
// Revision: 1.0
// ============================================================================
`default_nettype none

package nibble_logic_unit_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_logic_unit_logic_chunk.sv
// ============================================================================
// logic_chunk : combinational CHUNK-bit AND/OR/XOR/NOR slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module logic_chunk
  import nibble_logic_unit_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nibble_logic_unit.sv
// ============================================================================
// nibble_logic_unit : iterative bitwise logic unit, CHUNK bits per clock,
//                     valid/ready on both operand and result sides
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_logic_unit
  import nibble_logic_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [1:0]        op_q;
  logic [CHUNK-1:0]  chunk_res;
  logic [WIDTH-1:0]  result_next;

  logic_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_q[int'(idx)*CHUNK +: CHUNK]),
    .b  (b_q[int'(idx)*CHUNK +: CHUNK]),
    .op (op_q),
    .y  (chunk_res)
  );

  // Zero flag must see the final chunk, so it is taken from the merged word.
  always_comb begin
    result_next = result;
    result_next[int'(idx)*CHUNK +: CHUNK] = chunk_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op;
            idx      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          result <= result_next;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            zero      <= (result_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_logic_unit.sv
// ============================================================================
// tb_nibble_logic_unit : directed + randomized bench against a word-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_logic_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  nibble_logic_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_result"},    result,         32'd0);
    check({tag, "_zero"},      32'(zero),      32'd0);
  endtask

  // Full transaction: accept, optionally scramble inputs during RUN,
  // hold DONE for `hold` cycles under backpressure, then release.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                        input int hold, input bit chaos);
    logic [31:0] exp;
    int cycles;
    exp = model(top, ta, tb_v);
    a = ta; b = tb_v; op = top; in_valid = 1'b1; out_ready = 1'b0;
    check("accept_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      check("run_in_ready", 32'(in_ready), 32'd0);
      if (chaos) begin
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        in_valid = 1'($urandom_range(0, 1));
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cycles), 32'd8);
    check("result", result, exp);
    check("zero", 32'(zero), 32'(exp == 32'd0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      step();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", result, exp);
      check("hold_zero", 32'(zero), 32'(exp == 32'd0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  logic [31:0] exp_q[$];
  int          acc_t[$];
  int          n_acc;
  int          cyc;
  bit          will_acc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 2'd0;
    step(); step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();
    check_reset_outputs("idle");

    // Directed cases
    run_op(32'hF0F0_1234, 32'hFF00_00FF, 2'd0, 0, 1'b0);
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd2, 0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 2'd3, 0, 1'b0);
    run_op(32'h0000_FFFF, 32'hFFFF_0000, 2'd1, 0, 1'b0);

    // Backpressure with in_valid pulses, and input churn after acceptance
    run_op(32'h1357_9BDF, 32'h0246_8ACE, 2'd2, 5, 1'b1);
    for (int i = 0; i < 6; i++)
      run_op($urandom, $urandom, 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1);

    // Reset in the middle of RUN
    a = 32'hAAAA_5555; b = 32'h0F0F_F0F0; op = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    check_reset_outputs("midrun_reset");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check("no_stale_valid", 32'(out_valid), 32'd0);
    end
    run_op(32'h8000_0001, 32'h7FFF_FFFE, 2'd3, 1, 1'b0);

    // Reset and in_valid together: not accepted
    reset = 1'b1; in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1; op = 2'd0;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check_reset_outputs("reset_vs_valid");
    repeat (10) step();
    check("reset_vs_valid_no_out", 32'(out_valid), 32'd0);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1; n_acc = 0; cyc = 0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); in_valid = 1'b1;
    for (int i = 0; i < 80 && (n_acc < 4 || exp_q.size() > 0); i++) begin
      will_acc = in_valid && in_ready;
      if (will_acc) begin
        exp_q.push_back(model(op, a, b));
        acc_t.push_back(cyc);
        n_acc++;
      end
      step();
      cyc++;
      if (will_acc) begin
        if (n_acc < 4) begin
          a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("b2b_spurious", 32'd1, 32'd0);
        else check("b2b_result", result, exp_q.pop_front());
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", 32'(n_acc), 32'd4);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < acc_t.size(); i++)
      check("b2b_interval", 32'(acc_t[i] - acc_t[i-1]), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

`default_nettype wire
